// File: rtl/wn_pkg.sv
// Shared types and constants for the wn arithmetic pipeline and its output stages.
package wn_pkg;

    localparam int W_WIDTH = 19;
    localparam int W_FRAC  = 14;
    localparam int Q_WIDTH = 8;
    localparam int Q_FRAC  = 7;

    typedef logic signed [W_WIDTH-1:0] w_t;
    typedef logic signed [Q_WIDTH-1:0] q_t;

    typedef struct packed {
        q_t   data;
        logic sat;
    } q_entry_t;

endpackage

// File: rtl/wn_sync_fifo.sv
// Show-ahead synchronous FIFO; occupancy is held in an explicit counter.
// A push while full is ignored unless a pop happens in the same cycle.
module wn_sync_fifo
    import wn_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = q_entry_t
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  T                         wdata_i,
    input  logic                     pop_i,
    output T                         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wn_requant.sv
// Requantises Q5.14 samples to saturated Q1.7 and buffers them behind a ready/valid port.
// Define WN_REQUANT_ROUND_EN for round-half-up; otherwise the shift floors.
module wn_requant
    import wn_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [18:0]             w_i,
    input  logic                    valid_i,
    input  logic                    clr_i,
    output logic [7:0]              out_data_o,
    output logic                    out_sat_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    drop_o
);

    logic signed [19:0] w_ext;
    logic signed [19:0] w_sh;
    logic               unused_sh;
    logic signed [12:0] r_q, r_d;
    logic               s1_valid_q, s1_valid_d;
    logic               drop_q, drop_d;
    q_entry_t           entry;
    q_entry_t           head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

`ifdef WN_REQUANT_ROUND_EN
    assign w_ext = {w_i[18], w_i} + 20'sd64;
`else
    assign w_ext = {w_i[18], w_i};
`endif
    assign w_sh      = w_ext >>> 7;
    assign unused_sh = ^w_sh[19:13];

    always_comb begin
        r_d        = valid_i ? w_sh[12:0] : r_q;
        s1_valid_d = valid_i;
    end

    always_comb begin
        entry.data = r_q[7:0];
        entry.sat  = 1'b0;
        if (r_q > 13'sd127) begin
            entry.data = 8'h7F;
            entry.sat  = 1'b1;
        end else if (r_q < -13'sd128) begin
            entry.data = 8'h80;
            entry.sat  = 1'b1;
        end
    end

    assign pop = out_valid_o && out_ready_i;

    // Set has priority over clear so a loss in the clearing cycle is not hidden.
    always_comb begin
        drop_d = drop_q;
        if (clr_i) begin
            drop_d = 1'b0;
        end
        if (s1_valid_q && fifo_full && !pop) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q        <= '0;
            s1_valid_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            r_q        <= r_d;
            s1_valid_q <= s1_valid_d;
            drop_q     <= drop_d;
        end
    end

    wn_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (q_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (s1_valid_q),
        .wdata_i (entry),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_data_o  = head.data;
    assign out_sat_o   = head.sat;
    assign out_valid_o = !fifo_empty;
    assign drop_o      = drop_q;

endmodule

// File: tb/tb_wn_requant.sv
// Self-checking bench for wn_requant: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_wn_requant;
    import wn_pkg::*;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [18:0] w_i;
    logic        valid_i;
    logic        clr_i;
    logic [7:0]  out_data_o;
    logic        out_sat_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [2:0]  count_o;
    logic        drop_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        logic       sat;
    } exp_t;

    typedef struct {
        logic [18:0] w;
        logic [7:0]  data;
        logic        sat;
    } vec_t;

    exp_t mq[$];
    logic pend_v;
    exp_t pend_e;
    logic m_drop;

    always #5 clk_i = ~clk_i;

    wn_requant #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .w_i         (w_i),
        .valid_i     (valid_i),
        .clr_i       (clr_i),
        .out_data_o  (out_data_o),
        .out_sat_o   (out_sat_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .count_o     (count_o),
        .drop_o      (drop_o)
    );

    // Reference value: real-valued scaling by 2^-7 with floor (or half-up), then clamp.
    function automatic exp_t modelQ(input logic [18:0] w);
        exp_t e;
        int   v;
        int   m;
        int   r;
        v = int'($signed(w));
`ifdef WN_REQUANT_ROUND_EN
        v = v + 64;
`endif
        m = ((v % 128) + 128) % 128;
        r = (v - m) / 128;
        if (r > 127) begin
            e.data = 8'h7F; e.sat = 1'b1;
        end else if (r < -128) begin
            e.data = 8'h80; e.sat = 1'b1;
        end else begin
            e.data = 8'(r); e.sat = 1'b0;
        end
        return e;
    endfunction

    function automatic void modelReset();
        mq.delete();
        pend_v = 1'b0;
        m_drop = 1'b0;
    endfunction

    function automatic void modelEdge(input logic [18:0] w, input logic v,
                                      input logic rdy, input logic clr);
        bit was_full;
        bit popped;
        was_full = (mq.size() == DEPTH);
        popped   = (mq.size() > 0) && rdy;
        if (clr) m_drop = 1'b0;
        if (popped) void'(mq.pop_front());
        if (pend_v) begin
            if (was_full && !popped) m_drop = 1'b1;
            else mq.push_back(pend_e);
        end
        pend_v = v;
        if (v) pend_e = modelQ(w);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("count", 32'(count_o), 32'(mq.size()));
        checkOutput("valid", 32'(out_valid_o), 32'(mq.size() != 0));
        checkOutput("drop", 32'(drop_o), 32'(m_drop));
        if (mq.size() != 0) begin
            checkOutput("head_data", 32'(out_data_o), 32'(mq[0].data));
            checkOutput("head_sat", 32'(out_sat_o), 32'(mq[0].sat));
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid_o), 32'd0);
        checkOutput({tag, "_count"}, 32'(count_o), 32'd0);
        checkOutput({tag, "_drop"}, 32'(drop_o), 32'd0);
        checkOutput({tag, "_data"}, 32'(out_data_o), 32'd0);
        checkOutput({tag, "_sat"}, 32'(out_sat_o), 32'd0);
    endtask

    task automatic applyStimulus(input logic [18:0] w, input logic v,
                                 input logic rdy, input logic clr);
        w_i         = w;
        valid_i     = v;
        out_ready_i = rdy;
        clr_i       = clr;
        @(posedge clk_i);
        modelEdge(w, v, rdy, clr);
        #1;
        checkModel();
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{19'h02000, 8'h40, 1'b0});
        vecs.push_back('{19'h04000, 8'h7F, 1'b1});
        vecs.push_back('{19'h7C000, 8'h80, 1'b0});
        vecs.push_back('{19'h78000, 8'h80, 1'b1});
`ifdef WN_REQUANT_ROUND_EN
        vecs.push_back('{19'h000C0, 8'h02, 1'b0});
        vecs.push_back('{19'h7FF40, 8'hFF, 1'b0});
        vecs.push_back('{19'h03FC0, 8'h7F, 1'b1});
`else
        vecs.push_back('{19'h000C0, 8'h01, 1'b0});
        vecs.push_back('{19'h7FF40, 8'hFE, 1'b0});
        vecs.push_back('{19'h03FC0, 8'h7F, 1'b0});
`endif

        rst_ni      = 1'b0;
        w_i         = '0;
        valid_i     = 1'b0;
        clr_i       = 1'b0;
        out_ready_i = 1'b0;
        modelReset();
        #1;
        checkResetValues("reset");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Directed vectors: one sample at a time, visible after the second edge.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].w, 1'b1, 1'b1, 1'b0);
            checkOutput("tbl_not_yet_valid", 32'(out_valid_o), 32'd0);
            applyStimulus('0, 1'b0, 1'b1, 1'b0);
            checkOutput("tbl_valid", 32'(out_valid_o), 32'd1);
            checkOutput("tbl_data", 32'(out_data_o), 32'(vecs[i].data));
            checkOutput("tbl_sat", 32'(out_sat_o), 32'(vecs[i].sat));
            applyStimulus('0, 1'b0, 1'b1, 1'b0);
            checkOutput("tbl_count_back_to_0", 32'(count_o), 32'd0);
        end

        // Fill past capacity with the consumer stalled.
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(19'(i << 7), 1'b1, 1'b0, 1'b0);
        end
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("fill_count", 32'(count_o), 32'd4);
        checkOutput("fill_drop", 32'(drop_o), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("drain_order", 32'(out_data_o), 32'(i));
            applyStimulus('0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("drop_sticky", 32'(drop_o), 32'd1);
        applyStimulus('0, 1'b0, 1'b0, 1'b1);
        checkOutput("drop_cleared", 32'(drop_o), 32'd0);

        // Full FIFO with a pop every cycle: no drops, no gaps.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(19'((20 + i) << 7), 1'b1, 1'b0, 1'b0);
        end
        checkOutput("full_count", 32'(count_o), 32'd4);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(19'((25 + k) << 7), 1'b1, 1'b1, 1'b0);
            checkOutput("full_pop_count", 32'(count_o), 32'd4);
            checkOutput("full_pop_drop", 32'(drop_o), 32'd0);
            checkOutput("full_pop_seq", 32'(out_data_o), 32'(21 + k));
        end
        for (int k = 0; k < 6; k++) begin
            applyStimulus('0, 1'b0, 1'b1, 1'b0);
        end

        // Reset mid-stream with entries stored and samples still in flight.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(19'((40 + i) << 7), 1'b1, 1'b0, 1'b0);
        end
        valid_i = 1'b1;
        w_i     = 19'(44 << 7);
        rst_ni  = 1'b0;
        modelReset();
        #1;
        checkResetValues("midreset");
        #2;
        rst_ni = 1'b1;
        applyStimulus(19'(5 << 7), 1'b1, 1'b1, 1'b0);
        checkOutput("post_reset_no_stale", 32'(out_valid_o), 32'd0);
        applyStimulus('0, 1'b0, 1'b1, 1'b0);
        checkOutput("post_reset_valid", 32'(out_valid_o), 32'd1);
        checkOutput("post_reset_data", 32'(out_data_o), 32'd5);
        applyStimulus('0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            applyStimulus(19'($urandom), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
